// File: rtl/pcm_rxd_pkg.sv
// pcm_rxd_pkg: shared FSM states, line-code encodings and sync length helper for the PCM receiver.
package pcm_rxd_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, CHECK, LOCK} state_t;
  localparam logic [2:0] PAT_NRZL = 3'd0;
  localparam logic [2:0] PAT_NRZM = 3'd1;
  localparam logic [2:0] PAT_NRZS = 3'd2;
  function automatic logic [5:0] sync_bits(input logic [1:0] num);
    return num == 2'd0 ? 6'd32 : num == 2'd1 ? 6'd24 : 6'd16;
  endfunction
endpackage

// File: rtl/pcm_decrypt.sv
// pcm_decrypt: link synchroniser, sample-edge detector and NRZ-L/M/S decode.
module pcm_decrypt
  import pcm_rxd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       edge_i,
  input  logic [2:0] pattern_i,
  input  logic       pcm_clk_i,
  input  logic       pcm_data_i,
  output logic       bit_o,
  output logic       bit_valid_o
);
  logic [2:0] ck;
  logic [1:0] dt;
  logic       tick, smp, prev, dec;
  always_comb dec = pattern_i == PAT_NRZL ? smp :
                    pattern_i == PAT_NRZM ? smp ^ prev :
                    pattern_i == PAT_NRZS ? ~(smp ^ prev) : smp;
  // ck[1]/dt[1] are the synchronised link signals, ck[2] the edge-detect history
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ck <= '0;
      dt <= '0;
      tick <= 1'b0;
      smp <= 1'b0;
      prev <= 1'b0;
      bit_o <= 1'b0;
      bit_valid_o <= 1'b0;
    end else begin
      ck <= {ck[1:0], pcm_clk_i};
      dt <= {dt[0], pcm_data_i};
      tick <= edge_i ? (~ck[1] & ck[2]) : (ck[1] & ~ck[2]);
      smp <= dt[1];
      bit_valid_o <= tick & ~clr_i;
      if (tick) bit_o <= dec;
      prev <= clr_i ? 1'b0 : tick ? smp : prev;
    end
  end
endmodule

// File: rtl/pcm_rxd_top.sv
// pcm_rxd_top: PCM frame receiver with sync search/check/flywheel lock and payload byte delivery.
// PCM_RXD_SYNC_TOL_EN: when defined, a sync compare tolerates one differing bit.
module pcm_rxd_top
  import pcm_rxd_pkg::*;
#(
  parameter int SYNC_CHECK = 2,
  parameter int SYNC_MISS  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        edge_i,
  input  logic [2:0]  pattern_i,
  input  logic [15:0] length_i,
  input  logic [31:0] code_i,
  input  logic [1:0]  number_i,
  input  logic        pcm_clk_i,
  input  logic        pcm_data_i,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic        lock_o,
  output logic        cfg_err_o,
  output logic [31:0] frame_cnt_o,
  output logic [15:0] sync_err_cnt_o
);
  state_t      state;
  logic [2:0]  cfg_pattern;
  logic [15:0] cfg_len;
  logic [31:0] cfg_code, sr, mask, diff;
  logic [1:0]  cfg_num;
  logic [18:0] cnt, cnt_nx, len_bits, pay_bits;
  logic [7:0]  chk, miss;
  logic        bit_v, bit_d, step, match, boundary, byte_done;
  pcm_decrypt u_decrypt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(~enable_i),
    .edge_i(edge_i),
    .pattern_i(cfg_pattern),
    .pcm_clk_i(pcm_clk_i),
    .pcm_data_i(pcm_data_i),
    .bit_o(bit_d),
    .bit_valid_o(bit_v)
  );
  always_comb begin
    len_bits = {cfg_len, 3'b000};
    pay_bits = len_bits - {13'd0, sync_bits(cfg_num)};
    cnt_nx = cnt + 19'd1;
    boundary = cnt_nx == len_bits;
    byte_done = cnt_nx[2:0] == 3'd0 && cnt_nx <= pay_bits;
    mask = cfg_num == 2'd0 ? 32'hFFFF_FFFF : cfg_num == 2'd1 ? 32'h00FF_FFFF : 32'h0000_FFFF;
    diff = (sr ^ cfg_code) & mask;
`ifdef PCM_RXD_SYNC_TOL_EN
    match = ~cfg_err_o && $countones(diff) <= 1;
`else
    match = ~cfg_err_o && diff == 32'd0;
`endif
  end
  // step marks the cycle after a shift, when sr holds the newest bit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cfg_pattern <= '0;
      cfg_len <= '0;
      cfg_code <= '0;
      cfg_num <= '0;
      sr <= '0;
      cnt <= '0;
      chk <= '0;
      miss <= '0;
      step <= 1'b0;
      data_o <= '0;
      data_valid_o <= 1'b0;
      sof_o <= 1'b0;
      eof_o <= 1'b0;
      lock_o <= 1'b0;
      cfg_err_o <= 1'b0;
      frame_cnt_o <= '0;
      sync_err_cnt_o <= '0;
    end else if (!enable_i) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      chk <= '0;
      miss <= '0;
      step <= 1'b0;
      data_valid_o <= 1'b0;
      sof_o <= 1'b0;
      eof_o <= 1'b0;
      lock_o <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      sof_o <= 1'b0;
      eof_o <= 1'b0;
      step <= bit_v;
      if (bit_v) sr <= {sr[30:0], bit_d};
      case (state)
        IDLE: begin
          cfg_pattern <= pattern_i;
          cfg_len <= length_i;
          cfg_code <= code_i;
          cfg_num <= number_i;
          cfg_err_o <= {length_i, 3'b000} <= {13'd0, sync_bits(number_i)};
          state <= SEARCH;
        end
        SEARCH: if (step && match) begin
          state <= CHECK;
          cnt <= '0;
          chk <= '0;
        end
        CHECK: if (step) begin
          cnt <= boundary ? 19'd0 : cnt_nx;
          if (boundary && !match) state <= SEARCH;
          if (boundary && match) chk <= chk + 8'd1;
          if (boundary && match && chk + 8'd1 == 8'(SYNC_CHECK)) begin
            state <= LOCK;
            lock_o <= 1'b1;
            miss <= '0;
          end
        end
        LOCK: if (step) begin
          cnt <= boundary ? 19'd0 : cnt_nx;
          if (byte_done) begin
            data_o <= sr[7:0];
            data_valid_o <= 1'b1;
            sof_o <= cnt_nx == 19'd8;
            eof_o <= cnt_nx == pay_bits;
            if (cnt_nx == pay_bits) frame_cnt_o <= frame_cnt_o + 32'd1;
          end
          if (boundary) begin
            miss <= match ? 8'd0 : miss + 8'd1;
            if (!match && sync_err_cnt_o != 16'hFFFF) sync_err_cnt_o <= sync_err_cnt_o + 16'd1;
            if (!match && miss + 8'd1 == 8'(SYNC_MISS)) begin
              state <= SEARCH;
              lock_o <= 1'b0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pcm_rxd_top.sv
// tb_pcm_rxd_top: directed frame streams for the PCM receiver, checked against hand-computed bytes and counters.
module tb_pcm_rxd_top;
  logic        clk = 1'b0, rst, enable, edge_sel, pcm_clk, pcm_data, lvl;
  logic [2:0]  pattern;
  logic [15:0] length;
  logic [31:0] code;
  logic [1:0]  number;
  logic [7:0]  data;
  logic        data_valid, sof, eof, lock, cfg_err;
  logic [31:0] frame_cnt;
  logic [15:0] sync_err_cnt;
  logic [9:0]  q[$];
  int          vectors = 0, errors = 0, fc = 0;
`ifdef PCM_RXD_SYNC_TOL_EN
  localparam int TOL = 1;
`else
  localparam int TOL = 0;
`endif
  pcm_rxd_top dut (
    .clk_i(clk),
    .rst_i(rst),
    .enable_i(enable),
    .edge_i(edge_sel),
    .pattern_i(pattern),
    .length_i(length),
    .code_i(code),
    .number_i(number),
    .pcm_clk_i(pcm_clk),
    .pcm_data_i(pcm_data),
    .data_o(data),
    .data_valid_o(data_valid),
    .sof_o(sof),
    .eof_o(eof),
    .lock_o(lock),
    .cfg_err_o(cfg_err),
    .frame_cnt_o(frame_cnt),
    .sync_err_cnt_o(sync_err_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (data_valid) q.push_back({sof, eof, data});
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // transmitter model: line level changes with clock low, receiver samples on the rising edge
  task automatic send_bit(input logic b);
    lvl = pattern == 3'd1 ? lvl ^ b : pattern == 3'd2 ? lvl ^ ~b : b;
    pcm_data = lvl;
    pcm_clk = 1'b0;
    #50;
    pcm_clk = 1'b1;
    #50;
  endtask
  task automatic send_frame(input logic [31:0] sync, input int sb, input int nb);
    logic [7:0] b;
    for (int i = sb - 1; i >= 0; i--) begin
      b = sync[i*8 +: 8];
      for (int k = 7; k >= 0; k--) send_bit(b[k]);
    end
    for (int i = 0; i < nb; i++) begin
      b = 8'(i);
      for (int k = 7; k >= 0; k--) send_bit(b[k]);
    end
    repeat (10) @(negedge clk);
  endtask
  task automatic check_frame(input string tag, input int nb);
    check({tag, "_nbytes"}, q.size(), nb);
    for (int i = 0; i < nb && i < q.size(); i++)
      check(tag, {22'd0, q[i]}, {22'd0, i == 0, i == nb - 1, 8'(i)});
    q.delete();
    check({tag, "_frame_cnt"}, frame_cnt, fc);
  endtask
  task automatic restart(input logic [2:0] pat, input logic [15:0] len, input logic [31:0] cd, input logic [1:0] num);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    pattern = pat;
    length = len;
    code = cd;
    number = num;
    lvl = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    q.delete();
  endtask
  initial begin
    rst = 1'b1;
    enable = 1'b0;
    edge_sel = 1'b0;
    pattern = 3'd0;
    length = 16'd8;
    code = 32'h0000_EB90;
    number = 2'd2;
    pcm_clk = 1'b0;
    pcm_data = 1'b0;
    lvl = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 0);
    check("rst_valid", {31'd0, data_valid}, 0);
    check("rst_sof_eof", {30'd0, sof, eof}, 0);
    check("rst_lock", {31'd0, lock}, 0);
    check("rst_cfg_err", {31'd0, cfg_err}, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_sync_err", {16'd0, sync_err_cnt}, 0);
    rst = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    // NRZ-L: three syncs (one search + two checks) before lock
    send_frame(32'hEB90, 2, 6);
    send_frame(32'hEB90, 2, 6);
    check("l_lock_pre", {31'd0, lock}, 0);
    check("l_no_bytes_pre", q.size(), 0);
    send_frame(32'hEB90, 2, 6);
    check("l_lock", {31'd0, lock}, 1);
    fc = 1;
    check_frame("l_f3", 6);
    send_frame(32'hEB90, 2, 6);
    fc = 2;
    check_frame("l_f4", 6);
    send_frame(32'hEB91, 2, 6);
    fc = 3;
    check("tol_1bit_err", {16'd0, sync_err_cnt}, 1 - TOL);
    check("tol_1bit_lock", {31'd0, lock}, 1);
    check_frame("l_f5", 6);
    send_frame(32'hEB90, 2, 6);
    fc = 4;
    check_frame("l_f6", 6);
    send_frame(32'hEB93, 2, 6);
    fc = 5;
    check("fly_err", {16'd0, sync_err_cnt}, 2 - TOL);
    check("fly_lock", {31'd0, lock}, 1);
    check_frame("fly_f7", 6);
    send_frame(32'hEB93, 2, 6);
    check("drop_err", {16'd0, sync_err_cnt}, 3 - TOL);
    check("drop_lock", {31'd0, lock}, 0);
    check_frame("drop_f8", 0);
    // NRZ-M then NRZ-S with the same payload
    restart(3'd1, 16'd8, 32'h0000_EB90, 2'd2);
    repeat (3) send_frame(32'hEB90, 2, 6);
    check("m_lock", {31'd0, lock}, 1);
    fc = 6;
    check_frame("m_f3", 6);
    restart(3'd2, 16'd8, 32'h0000_EB90, 2'd2);
    repeat (3) send_frame(32'hEB90, 2, 6);
    check("s_lock", {31'd0, lock}, 1);
    fc = 7;
    check_frame("s_f3", 6);
    // frame length 4 cannot hold a 4-byte sync plus payload
    restart(3'd0, 16'd4, 32'h0000_EB90, 2'd0);
    check("cfg_err_set", {31'd0, cfg_err}, 1);
    repeat (2) send_frame(32'hEB90, 2, 6);
    check("cfg_err_lock", {31'd0, lock}, 0);
    check_frame("cfg_err_bytes", 0);
    restart(3'd0, 16'd16, 32'h1ACF_FC1D, 2'd0);
    check("cfg_ok", {31'd0, cfg_err}, 0);
    repeat (3) send_frame(32'h1ACF_FC1D, 4, 12);
    check("c_lock", {31'd0, lock}, 1);
    fc = 8;
    check_frame("c_f3", 12);
    send_frame(32'h1ACF_FC1D, 4, 12);
    fc = 9;
    check_frame("c_f4", 12);
    // reset in the middle of a locked frame
    send_frame(32'h1ACF_FC1D, 4, 6);
    check("pre_rst_lock", {31'd0, lock}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_lock", {31'd0, lock}, 0);
    check("mrst_frame_cnt", frame_cnt, 0);
    check("mrst_sync_err", {16'd0, sync_err_cnt}, 0);
    check("mrst_valid", {29'd0, data_valid, sof, eof}, 0);
    check("mrst_data", {24'd0, data}, 0);
    q.delete();
    fc = 0;
    repeat (2) send_frame(32'h1ACF_FC1D, 4, 12);
    check("r_lock_pre", {31'd0, lock}, 0);
    send_frame(32'h1ACF_FC1D, 4, 12);
    check("r_lock", {31'd0, lock}, 1);
    fc = 1;
    check_frame("r_f3", 12);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pcm_rxd_top.md
# pcm_rxd_top

PCM frame receiver that recovers byte-aligned frames from a serial clock/data link driven by the team's PCM transmitter. Synchronises the link into the system clock domain, reverses the line-code pattern, and searches for the configured sync word. Locks onto the frame with a check/flywheel state machine and delivers payload bytes with frame markers. Sits opposite `pcm_txd_top` in the test loop, and later in the receive path of the data acquisition design.

## Interface
Parameters:
- `SYNC_CHECK`, 2: consecutive sync matches required to enter LOCK.
- `SYNC_MISS`, 2: consecutive sync misses in LOCK before falling back to SEARCH.

Ports:
- `clk_i`  in  1  main clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `enable_i`  in  1  receiver enable; low forces IDLE.
- `edge_i`  in  1  sample edge of `pcm_clk_i`: 0 rising, 1 falling.
- `pattern_i`  in  3  line code: 0 NRZ-L, 1 NRZ-M, 2 NRZ-S, others NRZ-L.
- `length_i`  in  16  frame length in bytes, sync included.
- `code_i`  in  32  sync code, right-aligned.
- `number_i`  in  2  sync length: 0 4 bytes, 1 3 bytes, 2 or 3 2 bytes.
- `pcm_clk_i`  in  1  link clock, asynchronous.
- `pcm_data_i`  in  1  link data, asynchronous.
- `data_o`  out  8  payload byte, MSB first on the wire.
- `data_valid_o`  out  1  one-cycle strobe for `data_o`.
- `sof_o`  out  1  asserted with the first payload byte of a frame.
- `eof_o`  out  1  asserted with the last payload byte of a frame.
- `lock_o`  out  1  frame lock status.
- `cfg_err_o`  out  1  illegal `length_i`.
- `frame_cnt_o`  out  32  frames delivered, wraps.
- `sync_err_cnt_o`  out  16  sync misses while locked, saturating at 0xFFFF.

## Operation
- **Input conditioning:** 2-flop synchronisers on `pcm_clk_i` and `pcm_data_i`, then an edge detector on the synced clock selected by `edge_i`. Each detected edge produces one bit-tick and samples the synced data.
- **Decode:**
  - NRZ-L: the bit is the sampled level.
  - NRZ-M: the bit is 1 when the level changed from the previous sample.
  - NRZ-S: the bit is 1 when the level did not change.
  - The previous-level register resets to 0.
- **Shift register:** a 32-bit register shifts in the decoded bit at the LSB. The compare uses the low 16, 24 or 32 bits against the same bits of `code_i`, per `number_i`.
- **Configuration latch:** `pattern_i`, `length_i`, `code_i` and `number_i` are latched when leaving IDLE. Changes afterwards are ignored until `enable_i` drops.
- **Length check:** when latched `length_i` is less than sync bytes + 1, `cfg_err_o` is 1 and the FSM stays in SEARCH without matching.
- **FSM states:**
  - IDLE → SEARCH when `enable_i` = 1.
  - SEARCH: compare on every bit-tick. A match → CHECK, with the frame bit counter cleared.
  - CHECK: count `length_i`×8 bits, then compare. A match increments the check count; reaching `SYNC_CHECK` → LOCK. A miss → SEARCH.
  - LOCK: compare at each frame boundary. A miss increments the miss count and `sync_err_cnt_o`, and the frame continues (flywheel). `SYNC_MISS` consecutive misses → SEARCH and `lock_o` = 0. A match clears the miss count.
  - `enable_i` = 0 in any state → IDLE, counters and byte assembly cleared, `frame_cnt_o` and `sync_err_cnt_o` retained.
- **Payload delivery:** only in LOCK, and only frames whose boundary matched or was flywheeled. Sync bytes are never output.
  - Bytes are assembled from bit 0 after the sync field.
  - `sof_o` marks payload byte 0. `eof_o` marks byte `length_i` − sync bytes − 1. A single payload byte carries both.
  - `frame_cnt_o` increments with `eof_o`.
- **Counter widths:** the frame bit counter is 19 bits, sized for `length_i`×8 with no overflow.

## Timing
- **Reset values:** all outputs 0; FSM IDLE; previous decode level 0.
- **Bit-tick latency:** 3 `clk_i` cycles after the `pcm_clk_i` edge: 2 synchroniser stages plus edge register.
- **Decode/compare:** the decoded bit is registered 1 cycle after the tick, and the compare result is valid the following cycle.
- **Payload output:** `data_valid_o` (and `sof_o`/`eof_o` when applicable) pulses exactly 1 cycle, 1 cycle after the 8th bit of a byte is shifted in.
- **Bit rate limit:** the bit period must be at least 4 `clk_i` cycles; faster links are unsupported.
- **Simultaneous events:** if `enable_i` falls in the same cycle as a byte completes, IDLE wins and no strobe is emitted.

## Configuration
- `PCM_RXD_SYNC_TOL_EN` defined: a sync compare passes with at most 1 differing bit. Applies in SEARCH, CHECK and LOCK.
- Not defined: exact match is required.
- The port list is identical in both builds.

## Structure
- Package `pcm_rxd_pkg` holds:
  - the FSM state enum (IDLE, SEARCH, CHECK, LOCK);
  - the pattern encodings (NRZ-L 3'd0, NRZ-M 3'd1, NRZ-S 3'd2);
  - a function mapping `number_i` to sync bit length (32/24/16).
- Sub-module `pcm_decrypt` holds the synchroniser, edge detector and pattern decode. It outputs `bit_o`/`bit_valid_o` to the framing FSM in `pcm_rxd_top`.

## Test plan
- **NRZ-L lock:** `code_i`=0xEB90, `number_i`=2, `length_i`=8, payload 0x00..0x05 repeated -> `lock_o` after 2 frames. Each later frame gives 6 strobes 0x00..0x05, `sof_o` on 0x00, `eof_o` on 0x05, `frame_cnt_o` +1 per frame.
- **NRZ-M/NRZ-S:** the same stream encoded by `pcm_txd_top` with `pattern_i`=1 then 2 -> identical payload bytes.
- **Flywheel:** corrupt the sync of one locked frame -> `lock_o` stays 1, `sync_err_cnt_o`=1, that frame's payload still delivered. Corrupt 2 consecutive frames -> `lock_o`=0, FSM in SEARCH.
- **Config/length error:** `number_i`=0, `length_i`=4 -> `cfg_err_o`=1, no lock. Then `enable_i` low/high with `length_i`=16 and `code_i`=0x1ACFFC1D -> lock, 12 bytes per frame.
- **Reset mid-frame:** `rst_i` held for 1 cycle while locked -> all outputs 0 next cycle, relock after 2 frames.
- **Tolerance (`PCM_RXD_SYNC_TOL_EN` defined):** one flipped sync bit -> no miss counted. Two flipped bits -> miss counted.
